water_supply_valve_sequencer: RTL and testbench

WATER_SUPPLY_VALVE_SEQUENCER -- requirements
Module: water_supply_valve_sequencer

---
 rtl/water_supply_valve_sequencer.sv | 147 ++++++++++++++
 tb/tb_water_supply_valve_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/water_supply_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : water_supply_valve_sequencer
// Description : Per-channel tank-fill valve sequencer. Each channel opens its
//               valve only after demand has been seen for DEBOUNCE+1
//               consecutive clocks. It closes immediately on demand loss and
//               then enforces a HOLDOFF quiet period. If MAX_OPEN is non-zero,
//               it latches a fault when the valve stays open for too long.
//               Channels are fully independent.
// Ports       : clk                       - system clock, rising edge
//               rst_n                     - asynchronous active-low reset
//               enable                    - global supply enable
//               water_sensors_conflicting - per-channel sensor conflict
//               high_water_level          - per-channel tank-full flag
//               fault_clear               - per-channel fault acknowledge
//               valvule                   - per-channel valve command (1=open)
//               fault                     - per-channel open-timeout fault
//               any_fault                 - OR of all fault bits
// Revision    : 1.0 - initial release
// ============================================================================
module water_supply_valve_sequencer #(
    parameter int CHANNELS = 2,
    parameter int DEBOUNCE = 4,
    parameter int HOLDOFF  = 8,
    parameter int MAX_OPEN = 100,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] water_sensors_conflicting,
    input  logic [CHANNELS-1:0] high_water_level,
    input  logic [CHANNELS-1:0] fault_clear,
    output logic [CHANNELS-1:0] valvule,
    output logic [CHANNELS-1:0] fault,
    output logic                any_fault
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMING  = 3'd1,
        ST_OPEN    = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLDOFF - 1);
    // MAX_OPEN == 0 disables the timeout, so the terminal count is unused then.
    localparam logic [CNT_W-1:0] c_max_last  = CNT_W'((MAX_OPEN > 0) ? (MAX_OPEN - 1) : 0);
    localparam logic             c_tmo_en    = (MAX_OPEN != 0);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            state_t           state_q;
            state_t           state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             valve_q;
            logic             fault_q;
            logic             w_demand;

            assign w_demand = enable & ~water_sensors_conflicting[i] & ~high_water_level[i];

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    ST_IDLE: begin
                        if (w_demand) begin
                            state_d = ST_ARMING;
                            cnt_d   = '0;
                        end
                    end
                    ST_ARMING: begin
                        if (!w_demand) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else if (cnt_q == c_deb_last) begin
                            state_d = ST_OPEN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end
                    ST_OPEN: begin
                        // Demand loss is checked first so it beats a timeout
                        // on the same edge.
                        if (!w_demand) begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = '0;
                        end else if (c_tmo_en && (cnt_q == c_max_last)) begin
                            state_d = ST_FAULT;
                            cnt_d   = '0;
                        end else if (cnt_q != c_cnt_max) begin
                            // Saturates only when the timeout is disabled.
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (cnt_q == c_hold_last) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + c_cnt_one;
                        end
                    end
                    ST_FAULT: begin
                        if (fault_clear[i]) begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = '0;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end

            // Outputs are decoded from the next state, so they are registered
            // and still change on the same edge as the state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    valve_q <= 1'b0;
                    fault_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    valve_q <= (state_d == ST_OPEN);
                    fault_q <= (state_d == ST_FAULT);
                end
            end

            assign valvule[i] = valve_q;
            assign fault[i]   = fault_q;
        end
    endgenerate

    assign any_fault = |fault;

endmodule
`default_nettype wire

// File: tb/tb_water_supply_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_water_supply_valve_sequencer
// Description : Scoreboard bench for water_supply_valve_sequencer. A stimulus
//               process pushes the expected outputs for each clock edge. A
//               separate monitor pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_water_supply_valve_sequencer;

    localparam int CH   = 2;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int MAXO = 100;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [CH-1:0] conf = '0;
    logic [CH-1:0] hw = '0;
    logic [CH-1:0] clr = '0;
    logic [CH-1:0] valvule;
    logic [CH-1:0] fault;
    logic          any_fault;

    water_supply_valve_sequencer #(
        .CHANNELS (CH),
        .DEBOUNCE (DEB),
        .HOLDOFF  (HOLD),
        .MAX_OPEN (MAXO),
        .CNT_W    (CW)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .enable                    (enable),
        .water_sensors_conflicting (conf),
        .high_water_level          (hw),
        .fault_clear               (clr),
        .valvule                   (valvule),
        .fault                     (fault),
        .any_fault                 (any_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] v;
        logic [CH-1:0] f;
        logic          a;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: counts consecutive demand samples, edges spent open,
    // and remaining quiet edges, instead of tracking named states.
    int run_len [CH];
    int open_age[CH];
    int hold_left[CH];
    bit is_open [CH];
    bit is_flt  [CH];

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            run_len[i]   = 0;
            open_age[i]  = 0;
            hold_left[i] = 0;
            is_open[i]   = 1'b0;
            is_flt[i]    = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit d;
        for (int i = 0; i < CH; i++) begin
            d = enable && !conf[i] && !hw[i];
            if (is_flt[i]) begin
                if (clr[i]) begin
                    is_flt[i]    = 1'b0;
                    hold_left[i] = HOLD;
                end
            end else if (hold_left[i] > 0) begin
                hold_left[i]--;
            end else if (is_open[i]) begin
                if (!d) begin
                    is_open[i]   = 1'b0;
                    hold_left[i] = HOLD;
                end else begin
                    open_age[i]++;
                    if (MAXO != 0 && open_age[i] == MAXO) begin
                        is_open[i] = 1'b0;
                        is_flt[i]  = 1'b1;
                    end
                end
            end else if (d) begin
                run_len[i]++;
                if (run_len[i] == DEB + 1) begin
                    is_open[i]  = 1'b1;
                    run_len[i]  = 0;
                    open_age[i] = 0;
                end
            end else begin
                run_len[i] = 0;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < CH; i++) begin
            e.v[i] = is_open[i];
            e.f[i] = is_flt[i];
        end
        e.a = |e.f;
        return e;
    endfunction

    // One clock edge: the model consumes the inputs the DUT samples there.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic bound_fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no event, expected event", what);
    endtask

    // Monitor: independent of the stimulus, compares one expectation per edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({valvule, fault, any_fault} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got valvule=%b fault=%b any_fault=%b, expected valvule=%b fault=%b any_fault=%b",
                             $time, valvule, fault, any_fault, e.v, e.f, e.a);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        model_reset();

        // Reset held across a few edges: all outputs stay low.
        rst_n = 1'b0;
        cycles(3);
        #5 rst_n = 1'b1;

        // Ch0 demand held, ch1 blocked: ch0 opens on the 5th edge.
        enable = 1'b1;
        hw     = 2'b10;
        cycles(8);

        // Close ch0, let holdoff expire, then glitch demand mid-arming.
        hw = 2'b11;
        cycles(HOLD + 2);
        hw = 2'b10;
        cycles(3);
        conf[0] = 1'b1;
        cycles(1);
        conf[0] = 1'b0;
        cycles(7);

        // One-cycle high-water pulse while open: close, holdoff, reopen.
        hw[0] = 1'b1;
        cycles(1);
        hw[0] = 1'b0;
        cycles(16);

        // Demand held until the open timeout faults ch0.
        n = 0;
        while (!is_flt[0] && n < 150) begin
            step();
            n++;
        end
        if (!is_flt[0]) bound_fail("ch0_fault_wait");
        cycles(5);
        clr[0] = 1'b1;
        cycles(1);
        clr[0] = 1'b0;
        cycles(HOLD + DEB + 4);

        // Demand loss on exactly the timeout edge: no fault.
        n = 0;
        while (!(is_open[0] && open_age[0] == MAXO - 1) && n < 200) begin
            step();
            n++;
        end
        if (!(is_open[0] && open_age[0] == MAXO - 1)) bound_fail("ch0_age_wait");
        hw[0] = 1'b1;
        cycles(1);
        hw[0] = 1'b0;
        cycles(3);

        // Fault ch1, then open ch0, then assert reset between edges.
        hw = 2'b01;
        n = 0;
        while (!is_flt[1] && n < 150) begin
            step();
            n++;
        end
        if (!is_flt[1]) bound_fail("ch1_fault_wait");
        hw = 2'b00;
        n = 0;
        while (!is_open[0] && n < 30) begin
            step();
            n++;
        end
        if (!is_open[0]) bound_fail("ch0_open_wait");
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (valvule !== 2'b00 || fault !== 2'b00 || any_fault !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valvule=%b fault=%b any_fault=%b, expected valvule=00 fault=00 any_fault=0",
                     valvule, fault, any_fault);
        end
        model_reset();
        cycles(2);
        #5 rst_n = 1'b1;
        cycles(DEB + 3);

        // Randomized traffic.
        repeat (1500) begin
            enable = ($urandom_range(0, 15) != 0);
            for (int i = 0; i < CH; i++) begin
                conf[i] = ($urandom_range(0, 19) == 0);
                hw[i]   = ($urandom_range(0, 19) == 0);
                clr[i]  = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        clr = '0;

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) bound_fail("scoreboard_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
